// File: rtl/n163_sndram_arbiter_if.sv
// Bus bundle for the N163 sound-RAM arbiter: CPU port, mixer request/ack client and RAM port.
// The arbiter connects through the slave modport; its environment uses the master modport.
interface n163_sndram_arbiter_if;
    logic        ce;
    logic        prg_write;
    logic        prg_read;
    logic [15:0] prg_ain;
    logic [7:0]  prg_din;
    logic [7:0]  cpu_dout;
    logic        cpu_oe;
    logic        mix_req;
    logic [6:0]  mix_addr;
    logic        mix_ack;
    logic [7:0]  mix_data;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [3:0]  active_ch;

    modport slave (
        input  ce, prg_write, prg_read, prg_ain, prg_din,
        input  mix_req, mix_addr, ram_rdata,
        output cpu_dout, cpu_oe, mix_ack, mix_data,
        output ram_addr, ram_we, ram_wdata, active_ch
    );

    modport master (
        output ce, prg_write, prg_read, prg_ain, prg_din,
        output mix_req, mix_addr, ram_rdata,
        input  cpu_dout, cpu_oe, mix_ack, mix_data,
        input  ram_addr, ram_we, ram_wdata, active_ch
    );
endinterface

// File: rtl/n163_sndram_arbiter.sv
// Namco 163 sound RAM sequencer: shares one single-port RAM between CPU data-port
// writes/prefetch reads and wavetable mixer fetches; tracks the enabled-channel count.
module n163_sndram_arbiter (
    input  logic                        clk,
    input  logic                        reset,
    n163_sndram_arbiter_if.slave        bus
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR       = 3'd1;
    localparam logic [2:0] ST_PF_ISSUE = 3'd2;
    localparam logic [2:0] ST_PF_WAIT  = 3'd3;
    localparam logic [2:0] ST_MX_ISSUE = 3'd4;
    localparam logic [2:0] ST_MX_WAIT  = 3'd5;

    logic [2:0] state_reg, state_next;
    logic [6:0] addr_reg, addr_next;
    logic       autoinc_reg, autoinc_next;
    logic       wr_pend_reg, wr_pend_next;
    logic [6:0] wr_addr_reg;
    logic [7:0] wr_data_reg;
    logic       pf_pend_reg, pf_pend_next;
    logic [7:0] prefetch_reg, prefetch_next;
    logic       mix_ack_reg, mix_ack_next;
    logic [7:0] mix_data_reg, mix_data_next;
    logic [6:0] ram_addr_reg, ram_addr_next;
    logic       ram_we_reg, ram_we_next;
    logic [7:0] ram_wdata_reg, ram_wdata_next;
    logic [2:0] nch_reg;

    logic data_sel, addr_sel, wr_now, aw_now, rd_now, pf_set_now, arbitrate;

    assign data_sel   = (bus.prg_ain[15:11] == 5'b01001);
    assign addr_sel   = (bus.prg_ain[15:11] == 5'b11111);
    assign wr_now     = bus.ce & bus.prg_write & data_sel;
    assign aw_now     = bus.ce & bus.prg_write & addr_sel;
    assign rd_now     = bus.ce & bus.prg_read & data_sel;
    assign pf_set_now = aw_now | wr_now | (rd_now & autoinc_reg);

    // addr_next already includes this cycle's CPU event, so a prefetch issued
    // in the same cycle targets the up-to-date address.
    always_comb begin
        addr_next    = addr_reg;
        autoinc_next = autoinc_reg;
        if (aw_now) begin
            addr_next    = bus.prg_din[6:0];
            autoinc_next = bus.prg_din[7];
        end else if ((wr_now || rd_now) && autoinc_reg) begin
            addr_next = addr_reg + 7'd1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ram_addr_next  = ram_addr_reg;
        ram_we_next    = 1'b0;
        ram_wdata_next = ram_wdata_reg;
        prefetch_next  = prefetch_reg;
        mix_ack_next   = 1'b0;
        mix_data_next  = mix_data_reg;
        wr_pend_next   = wr_pend_reg | wr_now;
        pf_pend_next   = pf_pend_reg | pf_set_now;
        arbitrate      = 1'b0;

        case (state_reg)
            ST_IDLE:     arbitrate = 1'b1;
            ST_WR: begin
                state_next    = ST_PF_ISSUE;
                ram_addr_next = addr_next;
                pf_pend_next  = 1'b0;
            end
            ST_PF_ISSUE: state_next = ST_PF_WAIT;
            // Prefetch data lands here; arbitrating immediately keeps the
            // mixer's worst-case wait at write plus prefetch.
            ST_PF_WAIT: begin
                prefetch_next = bus.ram_rdata;
                arbitrate     = 1'b1;
            end
            ST_MX_ISSUE: state_next = ST_MX_WAIT;
            ST_MX_WAIT: begin
                mix_data_next = bus.ram_rdata;
                mix_ack_next  = 1'b1;
                state_next    = ST_IDLE;
            end
            default:     state_next = ST_IDLE;
        endcase

        if (arbitrate) begin
            state_next = ST_IDLE;
            if (wr_now || wr_pend_reg) begin
                state_next     = ST_WR;
                ram_we_next    = 1'b1;
                ram_addr_next  = wr_now ? addr_reg : wr_addr_reg;
                ram_wdata_next = wr_now ? bus.prg_din : wr_data_reg;
                wr_pend_next   = 1'b0;
            end else if (pf_pend_reg || pf_set_now) begin
                state_next    = ST_PF_ISSUE;
                ram_addr_next = addr_next;
                pf_pend_next  = 1'b0;
            end else if (bus.mix_req && !mix_ack_reg) begin
                state_next    = ST_MX_ISSUE;
                ram_addr_next = bus.mix_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= 7'd0;
            autoinc_reg   <= 1'b0;
            wr_pend_reg   <= 1'b0;
            wr_addr_reg   <= 7'd0;
            wr_data_reg   <= 8'd0;
            pf_pend_reg   <= 1'b1;
            prefetch_reg  <= 8'd0;
            mix_ack_reg   <= 1'b0;
            mix_data_reg  <= 8'd0;
            ram_addr_reg  <= 7'd0;
            ram_we_reg    <= 1'b0;
            ram_wdata_reg <= 8'd0;
            nch_reg       <= 3'd0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            autoinc_reg   <= autoinc_next;
            wr_pend_reg   <= wr_pend_next;
            pf_pend_reg   <= pf_pend_next;
            prefetch_reg  <= prefetch_next;
            mix_ack_reg   <= mix_ack_next;
            mix_data_reg  <= mix_data_next;
            ram_addr_reg  <= ram_addr_next;
            ram_we_reg    <= ram_we_next;
            ram_wdata_reg <= ram_wdata_next;
            if (wr_now) begin
                wr_addr_reg <= addr_reg;
                wr_data_reg <= bus.prg_din;
                if (addr_reg == 7'h7F)
                    nch_reg <= bus.prg_din[6:4];
            end
        end
    end

    assign bus.cpu_dout  = prefetch_reg;
    assign bus.cpu_oe    = bus.prg_read & data_sel;
    assign bus.mix_ack   = mix_ack_reg;
    assign bus.mix_data  = mix_data_reg;
    assign bus.ram_addr  = ram_addr_reg;
    assign bus.ram_we    = ram_we_reg;
    assign bus.ram_wdata = ram_wdata_reg;
    assign bus.active_ch = {1'b0, nch_reg} + 4'd1;
endmodule

// File: tb/tb_n163_sndram_arbiter.sv
// Directed scoreboard bench for n163_sndram_arbiter with a behavioural 128-byte sync RAM.
module tb_n163_sndram_arbiter;
    logic clk;
    logic reset;
    logic mem_init;
    int   cyc;
    int   n_pass;
    int   n_total;
    logic [7:0] mem [0:127];

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } mix_exp_t;

    mix_exp_t   mix_q[$];
    logic [7:0] cpu_q[$];

    n163_sndram_arbiter_if mif ();

    n163_sndram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous read-first RAM: data valid one clk after ram_addr.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            mem[8'h00] <= 8'h5A;
            mem[8'h40] <= 8'hA5;
            mem[8'h41] <= 8'h3C;
        end else begin
            if (mif.ram_we) mem[mif.ram_addr] <= mif.ram_wdata;
            mif.ram_rdata <= mem[mif.ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got %0h expected %0h ok (cyc %0d)", name, act, exp, cyc);
        end else begin
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_op(input logic wr, input logic [15:0] a, input logic [7:0] d);
        mif.ce        = 1'b1;
        mif.prg_write = wr;
        mif.prg_read  = ~wr;
        mif.prg_ain   = a;
        mif.prg_din   = d;
        tick(1);
        mif.ce        = 1'b0;
        mif.prg_write = 1'b0;
        mif.prg_read  = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a mixer ack or a CPU read.
    initial begin
        mix_exp_t e;
        logic [7:0] ce_exp;
        forever begin
            @(negedge clk);
            if (mif.mix_ack) begin
                if (mix_q.size() == 0) begin
                    n_total++;
                    $display("FAIL mix_ack_unexpected: got ack with data %0h expected no ack (cyc %0d)",
                             mif.mix_data, cyc);
                end else begin
                    e = mix_q.pop_front();
                    chk("mix_ack_cycle", cyc, e.cyc);
                    chk("mix_data", mif.mix_data, e.data);
                end
            end
            if (mif.ce && mif.prg_read && mif.cpu_oe) begin
                if (cpu_q.size() == 0) begin
                    n_total++;
                    $display("FAIL cpu_read_unexpected: got read data %0h expected none", mif.cpu_dout);
                end else begin
                    ce_exp = cpu_q.pop_front();
                    chk("cpu_read", mif.cpu_dout, ce_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        n_total++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        int c;
        n_pass = 0; n_total = 0; cyc = 0;
        reset = 1'b1; mem_init = 1'b1;
        mif.ce = 1'b0; mif.prg_write = 1'b0; mif.prg_read = 1'b0;
        mif.prg_ain = 16'h0000; mif.prg_din = 8'h00;
        mif.mix_req = 1'b0; mif.mix_addr = 7'h00; mif.ram_rdata = 8'h00;
        tick(2);
        mem_init = 1'b0;
        tick(1);

        // Reset state
        chk("rst_ram_addr", mif.ram_addr, 0);
        chk("rst_ram_we", mif.ram_we, 0);
        chk("rst_ram_wdata", mif.ram_wdata, 0);
        chk("rst_cpu_dout", mif.cpu_dout, 0);
        chk("rst_mix_ack", mif.mix_ack, 0);
        chk("rst_mix_data", mif.mix_data, 0);
        chk("rst_active_ch", mif.active_ch, 1);
        mif.prg_read = 1'b1; mif.prg_ain = 16'h4800; #1;
        chk("cpu_oe_4800", mif.cpu_oe, 1);
        mif.prg_ain = 16'hF800; #1;
        chk("cpu_oe_f800", mif.cpu_oe, 0);
        mif.prg_read = 1'b0; mif.prg_ain = 16'h0000;

        // Refresh prefetch after reset
        reset = 1'b0;
        tick(1);
        chk("post_rst_pf_addr", mif.ram_addr, 0);
        chk("post_rst_pf_we", mif.ram_we, 0);
        tick(2);
        chk("post_rst_prefetch", mif.cpu_dout, 8'h5A);

        // Autoinc writes to RAM[0..2]
        cpu_op(1'b1, 16'hF800, 8'h80); tick(4);
        cpu_op(1'b1, 16'h4800, 8'h11);
        chk("wr_c1_we", mif.ram_we, 1);
        chk("wr_c1_addr", mif.ram_addr, 7'h00);
        chk("wr_c1_wdata", mif.ram_wdata, 8'h11);
        tick(1);
        chk("wr_c2_we", mif.ram_we, 0);
        chk("wr_c2_pf_addr", mif.ram_addr, 7'h01);
        tick(1);
        chk("wr_c3_old_prefetch", mif.cpu_dout, 8'h5A);
        tick(1);
        chk("wr_c4_new_prefetch", mif.cpu_dout, 8'h00);
        cpu_op(1'b1, 16'h4800, 8'h22); tick(4);
        cpu_op(1'b1, 16'h4800, 8'h33); tick(4);
        chk("ram0", mem[0], 8'h11);
        chk("ram1", mem[1], 8'h22);
        chk("ram2", mem[2], 8'h33);

        // Address port then autoinc reads
        cpu_op(1'b1, 16'hF800, 8'h80);
        tick(1);
        chk("aw_c2_prefetch", mif.cpu_dout, 8'h00);
        tick(1);
        chk("aw_c3_prefetch", mif.cpu_dout, 8'h11);
        tick(2);
        cpu_q.push_back(8'h11); cpu_op(1'b0, 16'h4800, 8'h00); tick(4);
        cpu_q.push_back(8'h22); cpu_op(1'b0, 16'h4800, 8'h00); tick(4);
        cpu_q.push_back(8'h33); cpu_op(1'b0, 16'h4800, 8'h00); tick(4);

        // Autoinc wrap at $7F and channel-count shadow
        cpu_op(1'b1, 16'hF800, 8'hFF); tick(4);
        cpu_op(1'b1, 16'h4800, 8'h70);
        chk("wrap_wr_addr", mif.ram_addr, 7'h7F);
        chk("wrap_wr_we", mif.ram_we, 1);
        tick(1);
        chk("wrap_pf_addr", mif.ram_addr, 7'h00);
        tick(3);
        chk("ram7f_70", mem[127], 8'h70);
        chk("active_ch_8", mif.active_ch, 8);
        chk("wrap_prefetch", mif.cpu_dout, 8'h11);
        cpu_op(1'b1, 16'hF800, 8'h7F); tick(4);
        cpu_op(1'b1, 16'hFFFF, 8'h7F); tick(4);
        cpu_op(1'b1, 16'h4800, 8'h00);
        chk("noinc_wr_addr", mif.ram_addr, 7'h7F);
        chk("noinc_wr_wdata", mif.ram_wdata, 8'h00);
        tick(1);
        chk("noinc_pf_addr", mif.ram_addr, 7'h7F);
        tick(3);
        chk("active_ch_1", mif.active_ch, 1);
        chk("ram7f_00", mem[127], 8'h00);
        tick(1);

        // Mixer: single access then back-to-back with held request
        c = cyc;
        mif.mix_addr = 7'h40; mif.mix_req = 1'b1;
        mix_q.push_back('{c + 3, 8'hA5});
        tick(1);
        chk("mix_issue_addr", mif.ram_addr, 7'h40);
        tick(2);
        mif.mix_addr = 7'h41;
        mix_q.push_back('{c + 7, 8'h3C});
        tick(4);
        mif.mix_req = 1'b0;
        tick(2);

        // Contention: CPU write and mixer request in the same cycle
        cpu_op(1'b1, 16'hF800, 8'h40); tick(4);
        c = cyc;
        mif.ce = 1'b1; mif.prg_write = 1'b1; mif.prg_ain = 16'h4800; mif.prg_din = 8'h77;
        mif.mix_req = 1'b1; mif.mix_addr = 7'h40;
        mix_q.push_back('{c + 6, 8'h77});
        tick(1);
        mif.ce = 1'b0; mif.prg_write = 1'b0;
        chk("cont_c1_we", mif.ram_we, 1);
        chk("cont_c1_wdata", mif.ram_wdata, 8'h77);
        tick(1);
        chk("cont_c2_we", mif.ram_we, 0);
        tick(2);
        chk("cont_c4_prefetch", mif.cpu_dout, 8'h77);
        tick(2);
        mif.mix_req = 1'b0;
        tick(2);

        // Reset during MX_WAIT: no ack, everything back to reset values
        cpu_op(1'b1, 16'hF800, 8'h85); tick(4);
        mif.mix_addr = 7'h41; mif.mix_req = 1'b1;
        tick(2);
        reset = 1'b1; mif.mix_req = 1'b0;
        tick(1);
        chk("mrst_mix_ack", mif.mix_ack, 0);
        chk("mrst_mix_data", mif.mix_data, 0);
        chk("mrst_ram_addr", mif.ram_addr, 0);
        chk("mrst_ram_we", mif.ram_we, 0);
        chk("mrst_ram_wdata", mif.ram_wdata, 0);
        chk("mrst_cpu_dout", mif.cpu_dout, 0);
        reset = 1'b0;
        tick(3);
        chk("mrst_prefetch_addr0", mif.cpu_dout, 8'h11);
        cpu_q.push_back(8'h11); cpu_op(1'b0, 16'h4800, 8'h00);
        tick(5);
        chk("mrst_autoinc_cleared", mif.cpu_dout, 8'h11);
        tick(4);

        chk("mix_q_drained", mix_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/n163_sndram_arbiter.md
# n163_sndram_arbiter

Sequencer and arbiter for the Namco 163 internal 128-byte sound/wavetable RAM. It shares one single-port synchronous RAM between CPU data-port accesses at $4800 (with the $F800 address/auto-increment port) and the wavetable mixer's fetch requests. It makes sound RAM CPU-readable through a prefetch register, and tracks the enabled-channel count from register $7F. It sits between the mapper's CPU bus decode and the RAM instance, with the mixer as a request/ack client.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  CPU cycle enable; one clk pulse per CPU cycle, pulses ≥4 clk apart
- prg_write  in  1  CPU write strobe, qualified by ce
- prg_read  in  1  CPU read strobe, qualified by ce
- prg_ain  in  16  CPU address
- prg_din  in  8  CPU write data
- cpu_dout  out  8  read data for $4800–$4FFF (prefetch register)
- cpu_oe  out  1  combinational: prg_read & prg_ain[15:11]==5'b01001
- mix_req  in  1  mixer read request, held with mix_addr until mix_ack
- mix_addr  in  7  mixer RAM address
- mix_ack  out  1  one-clk pulse: mix_data valid
- mix_data  out  8  mixer read data
- ram_addr  out  7  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  8  RAM write data (registered)
- ram_rdata  in  8  RAM read data, valid 1 clk after ram_addr
- active_ch  out  4  enabled channels, 1..8

## Operation
- Address port: a write with ce and prg_ain[15:11]==5'b11111 loads {autoinc, addr[6:0]} <= prg_din and sets pf_pend.
- Data port write: a write with ce and prg_ain[15:11]==5'b01001 sets wr_pend with {addr, prg_din}. If autoinc, addr <= addr+1 (7-bit wrap, $7F→$00). Sets pf_pend in every case.
- Data port read: cpu_dout returns the prefetch register. If autoinc, addr <= addr+1 and pf_pend is set.
- Shadow register: a CPU write to RAM address $7F loads nch <= prg_din[6:4]. active_ch = nch+1.
- FSM states: IDLE, WR, PF_ISSUE, PF_WAIT, MX_ISSUE, MX_WAIT.
- Priority in IDLE: CPU write (pending, or detected this cycle) > prefetch > mixer.
  - IDLE→WR: ram_we=1, ram_addr=write addr, ram_wdata=data.
  - WR→PF_ISSUE.
  - IDLE→PF_ISSUE: ram_addr=addr.
  - PF_ISSUE→PF_WAIT: captures ram_rdata into prefetch; clears pf_pend unless addr changed meanwhile. PF_WAIT→IDLE.
  - IDLE→MX_ISSUE: ram_addr=mix_addr. MX_ISSUE→MX_WAIT: captures ram_rdata into mix_data; mix_ack=1 the next cycle. MX_WAIT→IDLE.
- IDLE ignores mix_req in any cycle where mix_ack=1.
- CPU events arriving in a non-IDLE state are latched and never dropped. A second data-port write before the first is serviced cannot occur, because of the ce spacing.
- In non-write states, ram_we=0 and ram_wdata holds its last value.

## Timing
- Reset values:
  - state=IDLE
  - addr=0, autoinc=0
  - wr_pend=0, pf_pend=1 (refresh after reset)
  - prefetch=0, cpu_dout=0
  - mix_ack=0, mix_data=0
  - ram_we=0, ram_addr=0, ram_wdata=0
  - nch=0, active_ch=1
- Reset mid-operation: any in-flight RAM write is abandoned at the reset edge (ram_we=0 the next cycle). Pending mixer access is dropped with no ack; the mixer must re-request.
- CPU write at ce cycle C, FSM idle:
  - C+1: WR, ram_we=1
  - C+2: PF_ISSUE at the new addr
  - C+3: PF_WAIT
  - from C+4: cpu_dout reflects RAM[new addr]
- Address-port write at C: prefetch is valid from C+3.
- Mixer request sampled at M, FSM idle:
  - M+1: MX_ISSUE
  - M+2: MX_WAIT
  - M+3: mix_ack=1, mix_data valid
- Minimum spacing between consecutive mixer accesses: 4 clk.
- Worst-case mixer wait per CPU event: 3 clk (write plus prefetch). A mixer access already issued always completes before a CPU op.
- Simultaneous ce write and mix_req in IDLE: the write wins; the mixer is served from C+4.

## Test plan
- Reset, then idle: ram_addr=0 PF_ISSUE at cycle 1 after reset, then cpu_dout=RAM[0]; active_ch=1; mix_ack=0.
- Write $F800←$80, then $4800←$11, $22, $33: RAM[0..2]=$11,$22,$33. Write $F800←$80 again, then read $4800 ×3 → cpu_dout $11,$22,$33.
- Autoinc wrap: $F800←$FF, write $4800←$70 → RAM[$7F]=$70, addr=$00, active_ch=8. Write $F800←$7F, then write $4800←$00 → addr stays $7F, active_ch=1.
- Mixer: hold mix_req with mix_addr=$40 (RAM[$40]=$A5) → mix_ack exactly once at M+3 with mix_data=$A5. Hold mix_req for back-to-back with mix_addr=$41 → second ack at M+7.
- Contention: ce write to $4800 in the same cycle mix_req rises → ram_we at C+1, prefetch at C+2, mixer ram_addr at C+4, mix_ack at C+6 with post-write data if the addresses match.
- Reset asserted during MX_WAIT → no mix_ack. All outputs take their reset values the next cycle; addr=0, autoinc=0.
